// File: rtl/axi4l_lsu_master_if.sv
// AXI4-Lite types and channel bundle shared by masters and slaves.
// Clock and reset travel with the bus so every endpoint sees the same pair.
package axi4l_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;
endpackage

interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  import axi4l_pkg::*;

  addr_t      awaddr;
  logic [2:0] awprot;
  logic       awvalid;
  logic       awready;

  data_t      wdata;
  strb_t      wstrb;
  logic       wvalid;
  logic       wready;

  resp_t      bresp;
  logic       bvalid;
  logic       bready;

  addr_t      araddr;
  logic [2:0] arprot;
  logic       arvalid;
  logic       arready;

  data_t      rdata;
  resp_t      rresp;
  logic       rvalid;
  logic       rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4l_lsu_master.sv
// Bridges one req/gnt/rvalid core memory port onto an AXI4-Lite master.
// One transaction in flight; AW and W retire independently.
module axi4l_lsu_master
  import axi4l_pkg::*;
#(
  parameter bit ALIGN = 1'b1
) (
  axi4l_if.master axi,
  input  logic    req_i,
  output logic    gnt_o,
  input  logic    we_i,
  input  strb_t   be_i,
  input  addr_t   addr_i,
  input  data_t   wdata_i,
  output logic    rvalid_o,
  output data_t   rdata_o,
  output logic    err_o
);
  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R
  } state_t;

  state_t state;
  addr_t  req_addr;
  logic   aw_left;
  logic   w_left;

  assign req_addr = ALIGN ? {addr_i[31:2], 2'b00} : addr_i;
  assign gnt_o    = (state == IDLE) && req_i;

  // a channel stays pending until its own valid&&ready
  assign aw_left  = axi.awvalid && !axi.awready;
  assign w_left   = axi.wvalid && !axi.wready;

  assign axi.awprot = 3'b000;
  assign axi.arprot = 3'b000;

  always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
    if (!axi.aresetn) begin
      state       <= IDLE;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      rvalid_o    <= 1'b0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_i) begin
            if (we_i) begin
              axi.awaddr  <= req_addr;
              axi.wdata   <= wdata_i;
              axi.wstrb   <= be_i;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= WR;
            end else begin
              axi.araddr  <= req_addr;
              axi.arvalid <= 1'b1;
              state       <= RD_AR;
            end
          end
        end
        WR: begin
          axi.awvalid <= aw_left;
          axi.wvalid  <= w_left;
          if (!aw_left && !w_left) begin
            axi.bready <= 1'b1;
            state      <= WR_B;
          end
        end
        WR_B: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            rvalid_o   <= 1'b1;
            err_o      <= axi.bresp[1];
            state      <= IDLE;
          end
        end
        RD_AR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RD_R;
          end
        end
        RD_R: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            rdata_o    <= axi.rdata;
            err_o      <= axi.rresp[1];
            rvalid_o   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4l_lsu_master.sv
// Random and directed traffic through the LSU master into a modelled slave.
// A queue of expected responses is checked whenever rvalid_o pulses.
module tb_axi4l_lsu_master;
  import axi4l_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4l_if axi  (.aclk(clk), .aresetn(rst_n));
  axi4l_if axi2 (.aclk(clk), .aresetn(rst_n));

  logic  req = 1'b0, we = 1'b0;
  strb_t be = '0;
  addr_t addr = '0;
  data_t wdata = '0;
  logic  gnt, rvalid, err, gnt2, rvalid2, err2;
  data_t rdata, rdata2;

  axi4l_lsu_master #(.ALIGN(1'b1)) dut (
    .axi(axi.master), .req_i(req), .gnt_o(gnt), .we_i(we),
    .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  axi4l_lsu_master #(.ALIGN(1'b0)) dut2 (
    .axi(axi2.master), .req_i(req), .gnt_o(gnt2), .we_i(we),
    .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rvalid2), .rdata_o(rdata2), .err_o(err2)
  );

  // the unaligned twin sees exactly the same slave behaviour
  assign axi2.awready = axi.awready;
  assign axi2.wready  = axi.wready;
  assign axi2.bvalid  = axi.bvalid;
  assign axi2.bresp   = axi.bresp;
  assign axi2.arready = axi.arready;
  assign axi2.rvalid  = axi.rvalid;
  assign axi2.rdata   = axi.rdata;
  assign axi2.rresp   = axi.rresp;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  localparam data_t ERR_DATA = 32'hBAD0_0BAD;

  // ---------------- reference model ----------------
  typedef struct {
    bit     rd;
    data_t  data;
    bit     err;
    int     lat;
    longint gcyc;
  } exp_t;

  exp_t  q[$];
  data_t mmem[int unsigned];
  addr_t cur_raw = '0;
  data_t cur_wd = '0;
  strb_t cur_be = '0;

  function automatic bit is_err(addr_t a);
    return (a >= 32'h800) && (a < 32'hA00);
  endfunction

  function automatic data_t mread(addr_t a);
    int unsigned k = a[31:2];
    return mmem.exists(k) ? mmem[k] : 32'h0;
  endfunction

  // ---------------- slave model ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  data_t smem[int unsigned];

  function automatic resp_t resp_of(addr_t a);
    if (a >= 32'h800 && a < 32'h900) return 2'b10;
    if (a >= 32'h900 && a < 32'hA00) return 2'b11;
    return 2'b00;
  endfunction

  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit aw_got, w_got, b_pend, r_pend;
    int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
    addr_t cap_aw, cap_ar, s_aw, s_ar;
    data_t cap_wd, s_wd, word;
    strb_t cap_ws, s_ws;
    {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
    {aw_got, w_got, b_pend, r_pend} = '0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0;
    axi.rvalid = 0; axi.rresp = 0; axi.rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
        {aw_got, w_got, b_pend, r_pend} = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.rvalid = 0;
        continue;
      end
      if (aw_hs) begin aw_got = 1; s_aw = cap_aw; end
      if (w_hs) begin w_got = 1; s_wd = cap_wd; s_ws = cap_ws; end
      if (b_hs) axi.bvalid = 0;
      if (r_hs) axi.rvalid = 0;
      if (ar_hs) begin r_pend = 1; r_wait = r_dly; s_ar = cap_ar; end
      if (aw_got && w_got) begin
        if (resp_of(s_aw) == 2'b00) begin
          word = smem.exists(s_aw[31:2]) ? smem[s_aw[31:2]] : 32'h0;
          for (int i = 0; i < 4; i++)
            if (s_ws[i]) word[8*i +: 8] = s_wd[8*i +: 8];
          smem[s_aw[31:2]] = word;
        end
        aw_got = 0; w_got = 0; b_pend = 1; b_wait = b_dly;
      end
      if (b_pend) begin
        if (b_wait == 0) begin
          axi.bvalid = 1; axi.bresp = resp_of(s_aw); b_pend = 0;
        end else b_wait--;
      end
      if (r_pend) begin
        if (r_wait == 0) begin
          axi.rvalid = 1;
          axi.rresp = resp_of(s_ar);
          if (resp_of(s_ar) != 2'b00) axi.rdata = ERR_DATA;
          else axi.rdata = smem.exists(s_ar[31:2]) ? smem[s_ar[31:2]] : 32'h0;
          r_pend = 0;
        end else r_wait--;
      end
      axi.awready = axi.awvalid && (aw_cnt >= aw_dly);
      aw_cnt = axi.awvalid ? aw_cnt + 1 : 0;
      axi.wready = axi.wvalid && (w_cnt >= w_dly);
      w_cnt = axi.wvalid ? w_cnt + 1 : 0;
      axi.arready = axi.arvalid && (ar_cnt >= ar_dly);
      ar_cnt = axi.arvalid ? ar_cnt + 1 : 0;
      aw_hs = axi.awvalid && axi.awready; cap_aw = axi.awaddr;
      w_hs = axi.wvalid && axi.wready; cap_wd = axi.wdata; cap_ws = axi.wstrb;
      ar_hs = axi.arvalid && axi.arready; cap_ar = axi.araddr;
      b_hs = axi.bvalid && axi.bready;
      r_hs = axi.rvalid && axi.rready;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t  e;
    data_t last_rd = '0;
    bit    p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0;
    addr_t p_awaddr = '0, p_araddr = '0;
    data_t p_wdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("rvalid_in_reset", rvalid, 0);
        last_rd = '0;
        {p_aw, p_awr, p_w, p_wr, p_ar, p_arr} = '0;
        continue;
      end
      chk("twin_rvalid", rvalid2, rvalid);
      if (rvalid) begin
        if (q.size() == 0) begin
          chk("unexpected_rvalid", rvalid, 0);
        end else begin
          e = q.pop_front();
          chk("err", err, e.err);
          if (e.rd) last_rd = e.data;
          chk(e.rd ? "rdata" : "rdata_kept", rdata, last_rd);
          if (e.lat > 0) chk("latency", 32'(cyc - e.gcyc), e.lat);
        end
      end
      if (p_aw && !p_awr) begin
        chk("awvalid_hold", axi.awvalid, 1);
        chk("awaddr_stable", axi.awaddr, p_awaddr);
      end
      if (p_w && !p_wr) begin
        chk("wvalid_hold", axi.wvalid, 1);
        chk("wdata_stable", axi.wdata, p_wdata);
      end
      if (p_ar && !p_arr) begin
        chk("arvalid_hold", axi.arvalid, 1);
        chk("araddr_stable", axi.araddr, p_araddr);
      end
      if (axi.awvalid) begin
        chk("awaddr_align", axi.awaddr, {cur_raw[31:2], 2'b00});
        chk("awaddr_raw", axi2.awaddr, cur_raw);
        chk("awprot", axi.awprot, 0);
      end
      if (axi.wvalid) begin
        chk("wdata", axi.wdata, cur_wd);
        chk("wstrb", axi.wstrb, cur_be);
      end
      if (axi.arvalid) begin
        chk("araddr_align", axi.araddr, {cur_raw[31:2], 2'b00});
        chk("araddr_raw", axi2.araddr, cur_raw);
      end
      p_aw = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
      p_w = axi.wvalid; p_wr = axi.wready; p_wdata = axi.wdata;
      p_ar = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(bit w, addr_t a, strb_t b, data_t d, int lat);
    int    waited = 0;
    bit    ok = 0;
    exp_t  e;
    addr_t al = {a[31:2], 2'b00};
    data_t word;
    req = 1; we = w; addr = a; be = b; wdata = d;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (gnt) begin ok = 1; break; end
      waited++;
      @(negedge clk);
    end
    if (!ok) begin
      chk("gnt_timeout", 0, 1);
    end else begin
      if (waited > 0) chk("b2b_gnt_with_rvalid", rvalid, 1);
      e.rd = !w; e.err = is_err(al); e.lat = lat; e.gcyc = cyc;
      e.data = '0;
      if (w && !e.err) begin
        word = mread(al);
        for (int i = 0; i < 4; i++)
          if (b[i]) word[8*i +: 8] = d[8*i +: 8];
        mmem[al[31:2]] = word;
      end
      if (!w) e.data = e.err ? ERR_DATA : mread(al);
      q.push_back(e);
      cur_raw = a; cur_wd = d; cur_be = b;
    end
    @(negedge clk);
    req = 0; we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic zero_delays();
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
  endtask

  initial begin
    int aw_n, w_n;
    bit ok;
    zero_delays();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    issue(1, 32'h10, 4'hF, 32'hDEADBEEF, 3);
    #1;
    chk("aw_at_plus1", axi.awvalid, 1);
    chk("w_at_plus1", axi.wvalid, 1);
    drain();
    issue(0, 32'h10, 4'hF, 32'h0, 3);
    drain();

    aw_dly = 3;
    issue(1, 32'h20, 4'h5, 32'hA5A5_1234, 0);
    aw_n = 0; w_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (axi.awvalid) aw_n++;
      if (axi.wvalid) w_n++;
      if (!axi.awvalid && !axi.wvalid) break;
      @(negedge clk);
    end
    chk("aw_held_cycles", aw_n, 4);
    chk("w_held_cycles", w_n, 1);
    drain();
    zero_delays();

    issue(0, 32'h804, 4'hF, 32'h0, 3);
    issue(0, 32'h10, 4'hF, 32'h0, 3);
    issue(1, 32'h900, 4'hF, 32'h1, 0);
    issue(0, 32'h20, 4'hF, 32'h0, 0);
    drain();

    b_dly = 6;
    issue(1, 32'h30, 4'hF, 32'h1234_5678, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (axi.bready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("reached_wr_b", ok, 1);
    #3 rst_n = 0;
    #1;
    chk("arst_awvalid", axi.awvalid, 0);
    chk("arst_wvalid", axi.wvalid, 0);
    chk("arst_bready", axi.bready, 0);
    chk("arst_rvalid", rvalid, 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    zero_delays();
    @(negedge clk);
    issue(1, 32'h34, 4'hF, 32'hCAFE_F00D, 3);
    issue(0, 32'h34, 4'hF, 32'h0, 3);
    issue(0, 32'h30, 4'hF, 32'h0, 0);
    drain();

    issue(1, 32'h13, 4'h2, 32'h0000_7700, 0);
    issue(0, 32'h13, 4'hF, 32'h0, 0);
    drain();

    for (int n = 0; n < 300; n++) begin
      addr_t a;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      a = {26'($urandom_range(0, 15)), 4'($urandom), 2'($urandom)};
      a = {a[31:6], 6'($urandom_range(0, 15) << 2 | $urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = 32'h800 + 32'($urandom_range(0, 127) << 2);
      issue(1'($urandom), a, 4'($urandom), $urandom, 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
